// File: rtl/snoop_result_collector_pkg.sv
// Shared snoop definitions: address width, snoop result encoding and the
// priority merge used when several lookup sources report on one request.
package ParameterDefinitions;
  localparam int ADDRESS_SIZE = 32;

  typedef enum logic [1:0] {
    HIT   = 2'b00,
    HITM  = 2'b01,
    NOHIT = 2'b10
  } snoop_result;

  // HITM dominates HIT, which dominates NOHIT
  function automatic snoop_result snoop_result_merge(snoop_result a, snoop_result b);
    if (a == HITM || b == HITM) return HITM;
    if (a == HIT || b == HIT) return HIT;
    return NOHIT;
  endfunction
endpackage

// File: rtl/snoop_result_collector_stat.sv
// Saturating event counter; sticks at all-ones once reached.
module snoop_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/snoop_result_collector.sv
// Merges per-bank snoop lookup results into one in-order result per request,
// with output backpressure, per-type statistics and a sticky protocol error.
module snoop_result_collector
  import ParameterDefinitions::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDRESS_SIZE-1:0]        req_addr,
  input  logic [NUM_BANKS-1:0]           bank_rsp_valid,
  input  snoop_result [NUM_BANKS-1:0]    bank_rsp_result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDRESS_SIZE-1:0]        out_addr,
  output snoop_result                    out_result,
  output logic [CNT_W-1:0]               hit_cnt,
  output logic [CNT_W-1:0]               hitm_cnt,
  output logic [CNT_W-1:0]               nohit_cnt,
  output logic                           proto_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [ADDRESS_SIZE-1:0] addr_q [DEPTH];
  logic [ADDRESS_SIZE-1:0] addr_d [DEPTH];
  logic [NUM_BANKS-1:0]    done_q [DEPTH];
  logic [NUM_BANKS-1:0]    done_d [DEPTH];
  snoop_result             res_q  [DEPTH];
  snoop_result             res_d  [DEPTH];
  logic [DEPTH-1:0]        val_q, val_d;
  logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W-1:0]        bptr_q [NUM_BANKS];
  logic [PTR_W-1:0]        bptr_d [NUM_BANKS];
  logic [PTR_W:0]          cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    push, pop;

  assign req_ready  = (cnt_q != FULL);
  assign out_valid  = val_q[rd_q] && (&done_q[rd_q]);
  assign out_addr   = addr_q[rd_q];
  assign out_result = res_q[rd_q];
  assign proto_err  = err_q;
  assign push       = req_valid && req_ready;
  assign pop        = out_valid && out_ready;

  always_comb begin
    addr_d = addr_q;
    done_d = done_q;
    res_d  = res_q;
    val_d  = val_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    bptr_d = bptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    // A bank may only answer an entry that existed before this edge and that
    // it has not answered yet; anything else is dropped and flagged.
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_rsp_valid[b]) begin
        if (val_q[bptr_q[b]] && !done_q[bptr_q[b]][b]) begin
          done_d[bptr_q[b]][b] = 1'b1;
          res_d[bptr_q[b]]     = snoop_result_merge(res_d[bptr_q[b]], bank_rsp_result[b]);
          bptr_d[b]            = bptr_q[b] + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (push) begin
      addr_d[wr_q] = req_addr;
      done_d[wr_q] = '0;
      res_d[wr_q]  = NOHIT;
      val_d[wr_q]  = 1'b1;
      wr_d         = wr_q + 1'b1;
    end
    if (pop) begin
      val_d[rd_q] = 1'b0;
      rd_d        = rd_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        done_q[i] <= '0;
        res_q[i]  <= NOHIT;
      end
      for (int b = 0; b < NUM_BANKS; b++) bptr_q[b] <= '0;
      val_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      done_q <= done_d;
      res_q  <= res_d;
      bptr_q <= bptr_d;
      val_q  <= val_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  snoop_stat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst_n(rst_n), .en(pop && out_result == HIT), .cnt(hit_cnt)
  );
  snoop_stat_counter #(.CNT_W(CNT_W)) u_hitm_cnt (
    .clk(clk), .rst_n(rst_n), .en(pop && out_result == HITM), .cnt(hitm_cnt)
  );
  snoop_stat_counter #(.CNT_W(CNT_W)) u_nohit_cnt (
    .clk(clk), .rst_n(rst_n), .en(pop && out_result == NOHIT), .cnt(nohit_cnt)
  );
endmodule

// File: tb/tb_snoop_result_collector.sv
// Directed bench: per-cycle vector table plus hand sequences for error,
// saturation and asynchronous reset behaviour.
module tb_snoop_result_collector;
  import ParameterDefinitions::*;

  localparam int NB = 2;
  localparam int D  = 4;
  localparam int CW = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [NB-1:0]           bank_rsp_valid;
  snoop_result [NB-1:0]    bank_rsp_result;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRESS_SIZE-1:0] out_addr;
  snoop_result             out_result;
  logic [CW-1:0]           hit_cnt, hitm_cnt, nohit_cnt;
  logic                    proto_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  snoop_result_collector #(.NUM_BANKS(NB), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_result(bank_rsp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_result(out_result),
    .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt),
    .proto_err(proto_err)
  );

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [1:0]  bv;
    snoop_result r0, r1;
    logic        ordy;
    logic        e_rdy, e_ov, chk_d;
    logic [31:0] e_addr;
    snoop_result e_res;
    logic [3:0]  e_hit, e_hitm, e_nohit;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rv, logic [31:0] addr, logic [1:0] bv,
                              snoop_result r0, snoop_result r1, logic ordy,
                              logic e_rdy, logic e_ov, logic chk_d,
                              logic [31:0] e_addr, snoop_result e_res,
                              logic [3:0] e_hit, logic [3:0] e_hitm, logic [3:0] e_nohit);
    vec_t v;
    v.rv = rv; v.addr = addr; v.bv = bv; v.r0 = r0; v.r1 = r1; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.chk_d = chk_d; v.e_addr = e_addr;
    v.e_res = e_res; v.e_hit = e_hit; v.e_hitm = e_hitm; v.e_nohit = e_nohit;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_addr = '0;
    bank_rsp_valid = '0;
    bank_rsp_result[0] = NOHIT;
    bank_rsp_result[1] = NOHIT;
  endtask

  // request, both banks answer next cycle, result visible the cycle after
  task automatic txn(input logic [31:0] a, input snoop_result x0, input snoop_result x1,
                     input snoop_result er);
    out_ready = 1'b0;
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    idle();
    bank_rsp_valid = 2'b11; bank_rsp_result[0] = x0; bank_rsp_result[1] = x1;
    @(negedge clk);
    idle();
    chk("txn out_valid", {31'b0, out_valid}, 32'd1);
    chk("txn out_addr", out_addr, a);
    chk("txn out_result", {30'b0, out_result}, {30'b0, er});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();

    tbl.push_back(mk(1, 32'h1A40, 2'b00, NOHIT, NOHIT, 1, 1, 0, 1, 32'h0, NOHIT, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b11, NOHIT, HITM, 1, 1, 0, 0, 0, NOHIT, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 1, 1, 32'h1A40, HITM, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(1, 32'h100, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(1, 32'h200, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(1, 32'h300, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(1, 32'h400, 2'b01, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b01, NOHIT, NOHIT, 1, 0, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b01, NOHIT, NOHIT, 1, 0, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b01, NOHIT, NOHIT, 1, 0, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b10, NOHIT, HIT, 1, 0, 0, 0, 0, NOHIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b10, NOHIT, NOHIT, 1, 0, 1, 1, 32'h100, HIT, 0, 1, 0));
    tbl.push_back(mk(0, 0, 2'b10, NOHIT, HIT, 1, 1, 1, 1, 32'h200, NOHIT, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2'b10, NOHIT, NOHIT, 1, 1, 1, 1, 32'h300, HIT, 1, 1, 1));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 1, 1, 32'h400, NOHIT, 2, 1, 1));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 2, 1, 2));
    tbl.push_back(mk(1, 32'h5A0, 2'b00, NOHIT, NOHIT, 0, 1, 0, 0, 0, NOHIT, 2, 1, 2));
    tbl.push_back(mk(0, 0, 2'b11, HIT, HIT, 0, 1, 0, 0, 0, NOHIT, 2, 1, 2));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 0, 1, 1, 1, 32'h5A0, HIT, 2, 1, 2));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 1, 1, 32'h5A0, HIT, 2, 1, 2));
    tbl.push_back(mk(0, 0, 2'b00, NOHIT, NOHIT, 1, 1, 0, 0, 0, NOHIT, 3, 1, 2));

    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset out_result", {30'b0, out_result}, {30'b0, NOHIT});
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req_valid = tbl[i].rv; req_addr = tbl[i].addr;
      bank_rsp_valid = tbl[i].bv;
      bank_rsp_result[0] = tbl[i].r0; bank_rsp_result[1] = tbl[i].r1;
      out_ready = tbl[i].ordy;
      chk($sformatf("v%0d req_ready", i), {31'b0, req_ready}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      if (tbl[i].chk_d) begin
        chk($sformatf("v%0d out_addr", i), out_addr, tbl[i].e_addr);
        chk($sformatf("v%0d out_result", i), {30'b0, out_result}, {30'b0, tbl[i].e_res});
      end
      chk($sformatf("v%0d hit_cnt", i), {28'b0, hit_cnt}, {28'b0, tbl[i].e_hit});
      chk($sformatf("v%0d hitm_cnt", i), {28'b0, hitm_cnt}, {28'b0, tbl[i].e_hitm});
      chk($sformatf("v%0d nohit_cnt", i), {28'b0, nohit_cnt}, {28'b0, tbl[i].e_nohit});
      chk($sformatf("v%0d proto_err", i), {31'b0, proto_err}, 32'd0);
    end

    // stray bank1 response with nothing outstanding
    @(negedge clk);
    idle(); out_ready = 1'b0;
    bank_rsp_valid = 2'b10; bank_rsp_result[1] = HIT;
    @(negedge clk);
    idle();
    chk("stray proto_err set", {31'b0, proto_err}, 32'd1);
    @(negedge clk);
    chk("stray proto_err sticky", {31'b0, proto_err}, 32'd1);
    chk("stray no out_valid", {31'b0, out_valid}, 32'd0);
    txn(32'h777, HITM, HIT, HITM);
    chk("after stray hitm_cnt", {28'b0, hitm_cnt}, 32'd2);
    chk("after stray proto_err", {31'b0, proto_err}, 32'd1);

    // hit counter saturation (starts at 3)
    for (int k = 0; k < 17; k++) txn(32'h1000 + k, HIT, NOHIT, HIT);
    chk("sat hit_cnt", {28'b0, hit_cnt}, 32'hF);
    chk("sat hitm_cnt", {28'b0, hitm_cnt}, 32'd2);

    // async reset with two entries pending
    req_valid = 1'b1; req_addr = 32'hA0;
    @(negedge clk);
    req_addr = 32'hB0;
    bank_rsp_valid = 2'b01; bank_rsp_result[0] = HITM;
    @(negedge clk);
    idle();
    chk("pre-reset out_addr", out_addr, 32'hA0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_addr", out_addr, 32'd0);
    chk("rst out_result", {30'b0, out_result}, {30'b0, NOHIT});
    chk("rst hit_cnt", {28'b0, hit_cnt}, 32'd0);
    chk("rst hitm_cnt", {28'b0, hitm_cnt}, 32'd0);
    chk("rst nohit_cnt", {28'b0, nohit_cnt}, 32'd0);
    chk("rst proto_err", {31'b0, proto_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // response in the same cycle as allocation is a protocol error
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hC0;
    bank_rsp_valid = 2'b01; bank_rsp_result[0] = HITM;
    @(negedge clk);
    idle();
    chk("same-cycle proto_err", {31'b0, proto_err}, 32'd1);
    chk("same-cycle no out_valid", {31'b0, out_valid}, 32'd0);
    bank_rsp_valid = 2'b11; bank_rsp_result[0] = HIT; bank_rsp_result[1] = HIT;
    @(negedge clk);
    idle();
    chk("post-err out_valid", {31'b0, out_valid}, 32'd1);
    chk("post-err out_addr", out_addr, 32'hC0);
    chk("post-err out_result", {30'b0, out_result}, {30'b0, HIT});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post-err hit_cnt", {28'b0, hit_cnt}, 32'd1);
    chk("post-err out_valid low", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
